// File: rtl/ef_apb_req_pkg.sv
// Shared types and helpers for the ef_apb_requester APB3 initiator.
package ef_apb_req_pkg;

    localparam int unsigned EF_APB_DEF_ADDR_W  = 32;
    localparam int unsigned EF_APB_DEF_DATA_W  = 32;
    localparam int unsigned EF_APB_DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    // Clears the byte-lane bits of an address for a bus of data_w bits (power-of-two lanes).
    function automatic logic [63:0] align_mask(input int unsigned data_w);
        return ~(64'(data_w / 8) - 64'd1);
    endfunction

endpackage

// File: rtl/ef_apb_req_timer.sv
// ACCESS-phase wait-state counter; o_expired flags the last permitted wait cycle.
module ef_apb_req_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned W = (LIMIT < 2) ? 1 : $clog2(LIMIT);

    logic [W-1:0] r_count;

    // Asserted while the count of completed wait states is LIMIT-1, so an
    // unready cycle now would make LIMIT wait states in total.
    assign o_expired = (r_count == W'(LIMIT - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/ef_apb_requester.sv
// APB3 initiator: valid/ready command in, APB transfer, valid/ready response out.
// Optional ACCESS timeout enabled by defining EF_APB_REQ_TIMEOUT_EN.
module ef_apb_requester
    import ef_apb_req_pkg::*;
#(
    parameter int unsigned ADDR_W         = EF_APB_DEF_ADDR_W,
    parameter int unsigned DATA_W         = EF_APB_DEF_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = EF_APB_DEF_TIMEOUT
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic              PSEL,
    output logic              PENABLE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    localparam logic [ADDR_W-1:0] LP_ADDR_MASK = ADDR_W'(align_mask(DATA_W));

    if (TIMEOUT_CYCLES == 0) begin : g_cfg_check
        $error("ef_apb_requester: TIMEOUT_CYCLES must be at least 1");
    end

    apb_state_t        r_state;
    apb_state_t        w_next;
    logic [ADDR_W-1:0] r_addr;
    logic              r_write;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic              w_abort;

`ifdef EF_APB_REQ_TIMEOUT_EN
    logic w_tmr_clear;
    logic w_tmr_enable;
    logic w_expired;

    assign w_tmr_clear  = (r_state == SETUP);
    assign w_tmr_enable = (r_state == ACCESS) && !PREADY;
    assign w_abort      = w_tmr_enable && w_expired;

    ef_apb_req_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk    (PCLK),
        .i_rst    (PRESET),
        .i_clear  (w_tmr_clear),
        .i_enable (w_tmr_enable),
        .o_expired(w_expired)
    );
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) w_next = SETUP;
            end
            SETUP: begin
                PSEL   = 1'b1;
                w_next = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY || w_abort) w_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (r_state == IDLE && cmd_valid) begin
                r_addr  <= cmd_addr & LP_ADDR_MASK;
                r_write <= cmd_write;
                r_wdata <= cmd_wdata;
            end
            if (r_state == ACCESS) begin
                if (PREADY) begin
                    r_rdata <= r_write ? '0 : PRDATA;
                    r_err   <= 1'b0;
                end else if (w_abort) begin
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                end
            end
        end
    end

    assign PADDR     = r_addr;
    assign PWRITE    = r_write;
    assign PWDATA    = r_wdata;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_ef_apb_requester.sv
// Bench for ef_apb_requester: transaction-level model checked every cycle plus directed literal checks.
// Timeout scenarios run when EF_APB_REQ_TIMEOUT_EN is defined.
module tb_ef_apb_requester;

    localparam int unsigned TMO = 4;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    int n_tests = 0;
    int n_fail  = 0;

    ef_apb_requester #(
        .ADDR_W        (32),
        .DATA_W        (32),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .busy     (busy),
        .PADDR    (PADDR),
        .PWRITE   (PWRITE),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Transaction model: one transfer in flight, tracked by its age and wait count.
    logic        m_ok   = 1'b0;
    logic        m_txn  = 1'b0;
    logic        m_resp = 1'b0;
    int          m_age  = 0;
    int          m_wait = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic        m_write = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        m_err  = 1'b0;

    always @(posedge PCLK) begin
        if (PRESET) begin
            m_ok    <= 1'b1;
            m_txn   <= 1'b0;
            m_resp  <= 1'b0;
            m_age   <= 0;
            m_wait  <= 0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_write <= 1'b0;
            m_rdata <= '0;
            m_err   <= 1'b0;
        end else if (!m_txn) begin
            if (cmd_valid) begin
                m_txn   <= 1'b1;
                m_age   <= 0;
                m_wait  <= 0;
                m_addr  <= (cmd_addr / 4) * 4;
                m_write <= cmd_write;
                m_wdata <= cmd_wdata;
            end
        end else if (m_resp) begin
            if (rsp_ready) begin
                m_txn  <= 1'b0;
                m_resp <= 1'b0;
            end
        end else if (m_age == 0) begin
            m_age <= 1;
        end else if (PREADY) begin
            m_resp  <= 1'b1;
            m_rdata <= m_write ? 32'd0 : PRDATA;
            m_err   <= 1'b0;
        end else begin
            m_wait <= m_wait + 1;
`ifdef EF_APB_REQ_TIMEOUT_EN
            if (m_wait + 1 == TMO) begin
                m_resp  <= 1'b1;
                m_rdata <= 32'd0;
                m_err   <= 1'b1;
            end
`endif
        end
    end

    always @(negedge PCLK) begin
        if (m_ok) begin
            chk("cmd_ready", cmd_ready, !m_txn);
            chk("busy",      busy,      m_txn);
            chk("PSEL",      PSEL,      m_txn && !m_resp);
            chk("PENABLE",   PENABLE,   m_txn && !m_resp && (m_age != 0));
            chk("rsp_valid", rsp_valid, m_resp);
            chk("rsp_rdata", rsp_rdata, m_rdata);
            chk("rsp_err",   rsp_err,   m_err);
            chk("PADDR",     PADDR,     m_addr);
            chk("PWRITE",    PWRITE,    m_write);
            chk("PWDATA",    PWDATA,    m_wdata);
        end
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        PRDATA    = '0;
        PREADY    = 1'b1;
        tick();
        tick();
        chk("reset cmd_ready", cmd_ready, 1);
        chk("reset PSEL",      PSEL,      0);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset PADDR",     PADDR,     0);
        PRESET = 1'b0;
        tick();

        // Write 0x4 <- 0xA5, zero wait states.
        issue(1'b1, 32'h0000_0004, 32'h0000_00A5);
        rsp_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("wr setup PSEL",    PSEL,    1);
        chk("wr setup PENABLE", PENABLE, 0);
        chk("wr setup PADDR",   PADDR,   32'h4);
        chk("wr setup PWDATA",  PWDATA,  32'hA5);
        tick();
        chk("wr access PENABLE", PENABLE, 1);
        tick();
        chk("wr rsp_valid", rsp_valid, 1);
        chk("wr rsp_rdata", rsp_rdata, 0);
        chk("wr rsp_err",   rsp_err,   0);
        tick();
        chk("wr idle cmd_ready", cmd_ready, 1);
        rsp_ready = 1'b0;

        // Read 0x8 with three wait states.
        PREADY = 1'b0;
        PRDATA = 32'h0BAD_0BAD;
        issue(1'b0, 32'h0000_0008, 32'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("rd wait PENABLE", PENABLE, 1);
            chk("rd wait PADDR",   PADDR,   32'h8);
            tick();
        end
        chk("rd last PENABLE", PENABLE, 1);
        PREADY = 1'b1;
        PRDATA = 32'hDEAD_BEEF;
        tick();
        chk("rd rsp_valid", rsp_valid, 1);
        chk("rd rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Back-to-back read then write while the response is held off.
        PRDATA = 32'h5A5A_0001;
        issue(1'b0, 32'h0000_0010, 32'h0);
        tick();
        issue(1'b1, 32'h0000_0014, 32'h00C0_FFEE);
        tick();
        tick();
        chk("b2b rsp_rdata", rsp_rdata, 32'h5A5A_0001);
        for (int i = 0; i < 5; i++) begin
            chk("b2b stall cmd_ready", cmd_ready, 0);
            chk("b2b stall PSEL",      PSEL,      0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("b2b idle cmd_ready", cmd_ready, 1);
        rsp_ready = 1'b0;
        tick();
        cmd_valid = 1'b0;
        chk("b2b wr PADDR",  PADDR,  32'h14);
        chk("b2b wr PWRITE", PWRITE, 1);
        tick();
        tick();
        chk("b2b wr rsp_rdata", rsp_rdata, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Unaligned address is forced to the word boundary.
        issue(1'b1, 32'h0000_0007, 32'h0000_0011);
        tick();
        cmd_valid = 1'b0;
        chk("align PADDR", PADDR, 32'h4);
        rsp_ready = 1'b1;
        tick();
        tick();
        tick();
        rsp_ready = 1'b0;

        // Reset in the middle of ACCESS abandons the transfer.
        PREADY = 1'b0;
        issue(1'b0, 32'h0000_0030, 32'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("rst access PENABLE", PENABLE, 1);
        tick();
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        chk("rst PSEL",      PSEL,      0);
        chk("rst PENABLE",   PENABLE,   0);
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst cmd_ready", cmd_ready, 1);
        chk("rst PADDR",     PADDR,     0);
        PREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst no rsp", rsp_valid, 0);
        end

`ifdef EF_APB_REQ_TIMEOUT_EN
        // Four unready ACCESS cycles abort the transfer.
        PREADY = 1'b0;
        PRDATA = 32'h1234_5678;
        issue(1'b0, 32'h0000_0020, 32'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("tmo access PSEL", PSEL, 1);
            tick();
        end
        chk("tmo rsp_valid", rsp_valid, 1);
        chk("tmo rsp_err",   rsp_err,   1);
        chk("tmo rsp_rdata", rsp_rdata, 0);
        chk("tmo PSEL",      PSEL,      0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Ready on the fourth ACCESS cycle completes normally.
        issue(1'b0, 32'h0000_0024, 32'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("tmo2 access PSEL", PSEL, 1);
            tick();
        end
        PREADY = 1'b1;
        tick();
        chk("tmo2 rsp_valid", rsp_valid, 1);
        chk("tmo2 rsp_err",   rsp_err,   0);
        chk("tmo2 rsp_rdata", rsp_rdata, 32'h1234_5678);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
`else
        // Without the timeout, ACCESS waits as long as PREADY stays low.
        PREADY = 1'b0;
        PRDATA = 32'h1234_5678;
        issue(1'b0, 32'h0000_0020, 32'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("long wait PENABLE",   PENABLE,   1);
            chk("long wait rsp_valid", rsp_valid, 0);
            tick();
        end
        PREADY = 1'b1;
        tick();
        chk("long rsp_valid", rsp_valid, 1);
        chk("long rsp_err",   rsp_err,   0);
        chk("long rsp_rdata", rsp_rdata, 32'h1234_5678);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
`endif

        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ef_apb_requester.md
# ef_apb_requester

APB3 initiator that turns a simple valid/ready command stream into APB transfers and returns a valid/ready response. It is the requester end of the bus that the EF_UART_APB register interface responds on. It drives PSEL/PENABLE/PADDR/PWRITE/PWDATA and samples PRDATA/PREADY. Benches and SoC glue use it to reach any EF peripheral's APB slave port.

## Interface
- ADDR_W, 32, APB address width
- DATA_W, 32, APB data width (multiple of 8)
- TIMEOUT_CYCLES, 255, maximum ACCESS-phase wait states before abort (timeout build only, ≥1)
- PCLK  in  1  clock; all logic rising-edge
- PRESET  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  DATA_W  read data (0 for writes and aborts)
- rsp_err  out  1  transfer aborted by timeout
- busy  out  1  state != IDLE
- PADDR  out  ADDR_W  APB address
- PWRITE  out  1  APB direction
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB ready

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. One outstanding transfer.
- IDLE: cmd_ready=1. On handshake, register cmd_write/cmd_addr/cmd_wdata, go to SETUP.
- PADDR = registered address with low log2(DATA_W/8) bits forced to 0.
- SETUP: PSEL=1, PENABLE=0. Go to ACCESS unconditionally.
- ACCESS: PSEL=1, PENABLE=1. On PREADY=1: capture PRDATA into rsp_rdata (read) or load 0 (write), clear rsp_err, go to RESP.
- ACCESS with PREADY=0: hold; PADDR/PWRITE/PWDATA stay stable.
- RESP: rsp_valid=1, PSEL=PENABLE=0. On rsp_ready, go to IDLE. rsp_rdata/rsp_err stay stable while waiting.
- cmd_ready=0 outside IDLE; commands are never dropped, the source stalls.
- PADDR/PWRITE/PWDATA hold their last value in IDLE and RESP (no toggling between transfers).
- Reset values: state IDLE, cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0.
- PRESET in any state, including mid-ACCESS: next edge returns to IDLE with reset values. Transfer is abandoned and no response is produced.

## Timing
- Handshake at edge T gives SETUP in cycle T+1 and ACCESS in T+2.
- PREADY=1 in T+2 gives rsp_valid=1 in T+3.
- Each PREADY=0 cycle in ACCESS adds one cycle.
- rsp_ready=1 in T+3 gives IDLE in T+4. Next command is accepted at the earliest at edge T+4; minimum 4 cycles per transfer.
- All outputs are registered or decoded from the state register only. There is no combinational path from PRDATA/PREADY/cmd_* to any output.

## Configuration
- EF_APB_REQ_TIMEOUT_EN defined:
  - Wait counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When the count reaches TIMEOUT_CYCLES with PREADY still 0, go to RESP with rsp_err=1 and rsp_rdata=0.
  - PSEL/PENABLE drop on that transition.
  - PREADY=1 in the same cycle as the limit counts as normal completion (rsp_err=0).
- Not defined: no counter; ACCESS waits indefinitely; rsp_err is constant 0; TIMEOUT_CYCLES is ignored.

## Structure
- Package ef_apb_req_pkg holds:
  - FSM state enum (IDLE, SETUP, ACCESS, RESP)
  - default width constants
  - a function computing the alignment mask from DATA_W
- Sub-module ef_apb_req_timer: wait-state counter with clear/enable/expired. Instantiated only under EF_APB_REQ_TIMEOUT_EN.

## Test plan
- Write 0x0000_0004 ← 0x0000_00A5, PREADY tied 1 → SETUP and ACCESS one cycle each with PADDR=0x4, PWRITE=1, PWDATA=0xA5; rsp_valid at T+3 with rsp_rdata=0, rsp_err=0.
- Read 0x0000_0008, PREADY low 3 cycles, then PREADY=1 with PRDATA=0xDEAD_BEEF → ACCESS lasts 4 cycles with stable address; response 0xDEAD_BEEF at T+6.
- Back-to-back read then write with rsp_ready=0 for 5 cycles → second command stalled (cmd_ready=0) until the first response is consumed; no APB activity in between.
- cmd_addr=0x0000_0007 → PADDR=0x0000_0004.
- PRESET pulsed during ACCESS → next cycle PSEL=PENABLE=0, rsp_valid=0, cmd_ready=1; no response emitted.
- Timeout build, TIMEOUT_CYCLES=4, PREADY held 0 → abort after 4 wait states with rsp_err=1 and rsp_rdata=0. Repeat with PREADY=1 on the 4th wait-state cycle → rsp_err=0.
